// File: rtl/mips_multicycle_controller_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_LDA_WB,
    S_MEM_WR,
    S_JUMP,
    S_BRANCH,
    S_IMM_EX,
    S_C_EX,
    S_ALU_WB,
    S_TRAP
  } state_e;

  localparam logic [3:0] OP_LDA   = 4'b0000;
  localparam logic [3:0] OP_STA   = 4'b0001;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_BZ    = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b0111;
  localparam logic [3:0] OP_ADDI  = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_ANDI  = 4'b1010;
  localparam logic [3:0] OP_ORI   = 4'b1011;

  localparam int unsigned FN_MOVETO   = 0;
  localparam int unsigned FN_MOVEFROM = 1;
  localparam int unsigned FN_ADD      = 2;
  localparam int unsigned FN_SUB      = 3;
  localparam int unsigned FN_AND      = 4;
  localparam int unsigned FN_OR       = 5;
  localparam int unsigned FN_NOT      = 6;
  localparam int unsigned FN_NOP      = 7;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_NOT_B  = 3'b100;
  localparam logic [2:0] ALU_PASS_A = 3'b101;
  localparam logic [2:0] ALU_PASS_B = 3'b110;

  localparam logic [1:0] ASB_RI   = 2'b00;
  localparam logic [1:0] ASB_SEXT = 2'b01;
  localparam logic [1:0] ASB_ONE  = 2'b10;

  localparam logic [1:0] PCS_ALU   = 2'b00;
  localparam logic [1:0] PCS_IMM12 = 2'b01;
  localparam logic [1:0] PCS_PAGE  = 2'b10;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Instruction fields in, datapath strobes out, between controller and datapath.
interface mips_multicycle_controller_if;
  logic [3:0] opcode;
  logic [8:0] func;
  logic       MemWrite, MemRead, PCWrite, PCWriteCond, IOrD, IRWrite;
  logic       MemToReg, RegWrite, RegDst, AluSrcA, ImSel;
  logic [1:0] AluSrcB;
  logic [1:0] PCSrc;
  logic [2:0] AluOperation;
  logic       illegal;

  modport master (
    input  opcode, func,
    output MemWrite, MemRead, PCWrite, PCWriteCond, IOrD, IRWrite,
           MemToReg, RegWrite, RegDst, AluSrcA, ImSel,
           AluSrcB, PCSrc, AluOperation, illegal
  );

  modport slave (
    output opcode, func,
    input  MemWrite, MemRead, PCWrite, PCWriteCond, IOrD, IRWrite,
           MemToReg, RegWrite, RegDst, AluSrcA, ImSel,
           AluSrcB, PCSrc, AluOperation, illegal
  );
endinterface

// File: rtl/mips_multicycle_controller_ctype_alu_decode.sv
// C-type func decoder: one-hot func -> ALU op plus MOVETO/NOP/legal flags.
module ctype_alu_decode
  import mips_ctrl_pkg::*;
(
  input  logic [8:0] func,
  output logic [2:0] alu_op,
  output logic       is_moveto,
  output logic       is_nop,
  output logic       legal
);

  always_comb begin
    alu_op    = ALU_ADD;
    is_moveto = 1'b0;
    is_nop    = 1'b0;
    legal     = 1'b1;
    // Only single bits 0..7 are defined; zero, multi-hot or bit 8 fall to default.
    case (func)
      9'(1 << FN_MOVETO):   begin alu_op = ALU_PASS_A; is_moveto = 1'b1; end
      9'(1 << FN_MOVEFROM): alu_op = ALU_PASS_B;
      9'(1 << FN_ADD):      alu_op = ALU_ADD;
      9'(1 << FN_SUB):      alu_op = ALU_SUB;
      9'(1 << FN_AND):      alu_op = ALU_AND;
      9'(1 << FN_OR):       alu_op = ALU_OR;
      9'(1 << FN_NOT):      alu_op = ALU_NOT_B;
      9'(1 << FN_NOP):      is_nop = 1'b1;
      default:              legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Moore control FSM for the 16-bit accumulator multi-cycle MIPS datapath.
// Build option: ILLEGAL_TRAP_EN sends illegal instructions to TRAP instead of treating them as NOP.
module mips_multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_ONLY_RESET = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mips_multicycle_controller_if.master         bus
);

  // Restart in FETCH is the only supported reset behaviour.
  localparam state_e RESET_STATE = (FETCH_ONLY_RESET == 1) ? S_FETCH : S_FETCH;

`ifdef ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = S_TRAP;
`else
  localparam state_e ILLEGAL_NEXT = S_FETCH;
`endif

  state_e     state_q, state_d;
  logic       moveto_q, moveto_d;
  logic [2:0] c_aop_q, c_aop_d;

  logic [2:0] dec_aop;
  logic       dec_moveto, dec_nop, dec_legal;

  ctype_alu_decode u_ctype_dec (
    .func      (bus.func),
    .alu_op    (dec_aop),
    .is_moveto (dec_moveto),
    .is_nop    (dec_nop),
    .legal     (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RESET_STATE;
      moveto_q <= 1'b0;
      c_aop_q  <= ALU_ADD;
    end else begin
      state_q  <= state_d;
      moveto_q <= moveto_d;
      c_aop_q  <= c_aop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    moveto_d = moveto_q;
    c_aop_d  = c_aop_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        // Latch the C-type decode so C_EX/ALU_WB stay Moore even if IR fields move.
        moveto_d = (bus.opcode == OP_CTYPE) && dec_moveto;
        c_aop_d  = dec_aop;
        case (bus.opcode)
          OP_LDA:   state_d = S_MEM_RD;
          OP_STA:   state_d = S_MEM_WR;
          OP_JMP:   state_d = S_JUMP;
          OP_BZ:    state_d = S_BRANCH;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI:
                    state_d = S_IMM_EX;
          OP_CTYPE: begin
            if (!dec_legal)   state_d = ILLEGAL_NEXT;
            else if (dec_nop) state_d = S_FETCH;
            else              state_d = S_C_EX;
          end
          default:  state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEM_RD: state_d = S_LDA_WB;
      S_IMM_EX: state_d = S_ALU_WB;
      S_C_EX:   state_d = S_ALU_WB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.MemWrite     = 1'b0;
    bus.MemRead      = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.IOrD         = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.MemToReg     = 1'b0;
    bus.RegWrite     = 1'b0;
    bus.RegDst       = 1'b0;
    bus.AluSrcA      = 1'b0;
    bus.ImSel        = 1'b0;
    bus.AluSrcB      = ASB_RI;
    bus.PCSrc        = PCS_ALU;
    bus.AluOperation = ALU_ADD;
    bus.illegal      = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.IRWrite = 1'b1;
          bus.AluSrcB = ASB_ONE;
          bus.PCWrite = 1'b1;
        end
        S_MEM_RD: begin bus.IOrD = 1'b1; bus.MemRead  = 1'b1; end
        S_LDA_WB: begin bus.MemToReg = 1'b1; bus.RegWrite = 1'b1; end
        S_MEM_WR: begin bus.IOrD = 1'b1; bus.MemWrite = 1'b1; end
        S_JUMP:   begin bus.PCSrc = PCS_IMM12; bus.PCWrite = 1'b1; end
        S_BRANCH: begin
          bus.AluSrcA      = 1'b1;
          bus.AluOperation = ALU_PASS_A;
          bus.PCSrc        = PCS_PAGE;
          bus.PCWriteCond  = 1'b1;
        end
        S_IMM_EX: begin
          bus.AluSrcA = 1'b1;
          bus.AluSrcB = ASB_SEXT;
          bus.ImSel   = 1'b1;
        end
        S_C_EX: begin
          bus.AluSrcA      = 1'b1;
          bus.AluOperation = c_aop_q;
        end
        S_ALU_WB: begin bus.RegWrite = 1'b1; bus.RegDst = moveto_q; end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:   bus.illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: vector table plus reset/trap/latching sequences.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic       mw, mr, pcw, pcwc, iord, irw, m2r, rw, rdst, asa, imsel;
    logic [1:0] asb;
    logic [1:0] pcsrc;
    logic [2:0] aop;
    logic       ill;
  } outs_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [8:0]  fn;
    int unsigned lat;
    outs_t [3:0] exp;
  } vec_t;

  localparam outs_t O_ZERO   = '0;
  localparam outs_t O_FETCH  = '{mr:1'b1, irw:1'b1, pcw:1'b1, asb:2'b10, default:'0};
  localparam outs_t O_MEM_RD = '{iord:1'b1, mr:1'b1, default:'0};
  localparam outs_t O_LDA_WB = '{m2r:1'b1, rw:1'b1, default:'0};
  localparam outs_t O_MEM_WR = '{iord:1'b1, mw:1'b1, default:'0};
  localparam outs_t O_JUMP   = '{pcsrc:2'b01, pcw:1'b1, default:'0};
  localparam outs_t O_BRANCH = '{asa:1'b1, aop:3'b101, pcsrc:2'b10, pcwc:1'b1, default:'0};
  localparam outs_t O_IMM    = '{asa:1'b1, asb:2'b01, imsel:1'b1, default:'0};
  localparam outs_t O_WB     = '{rw:1'b1, default:'0};
  localparam outs_t O_WB_MT  = '{rw:1'b1, rdst:1'b1, default:'0};
  localparam outs_t O_TRAP   = '{ill:1'b1, default:'0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  vec_t vecs[$];

  mips_multicycle_controller_if bus ();

  mips_multicycle_controller #(.FETCH_ONLY_RESET(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic outs_t cex(input logic [2:0] a);
    outs_t o;
    o     = '0;
    o.asa = 1'b1;
    o.aop = a;
    return o;
  endfunction

  function automatic vec_t mkv(input string name, input logic [3:0] op, input logic [8:0] fn,
                               input int unsigned lat, input outs_t e2, input outs_t e3);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.lat = lat;
    v.exp[0] = O_FETCH; v.exp[1] = O_ZERO; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic chk(input string name, input outs_t exp);
    outs_t act;
    act = {bus.MemWrite, bus.MemRead, bus.PCWrite, bus.PCWriteCond, bus.IOrD, bus.IRWrite,
           bus.MemToReg, bus.RegWrite, bus.RegDst, bus.AluSrcA, bus.ImSel,
           bus.AluSrcB, bus.PCSrc, bus.AluOperation, bus.illegal};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    bus.opcode = v.op;
    bus.func   = v.fn;
    chk({v.name, "/c0"}, v.exp[0]);
    for (int unsigned k = 1; k < v.lat; k++) begin
      step();
      chk($sformatf("%s/c%0d", v.name, k), v.exp[k]);
    end
    step();
    chk({v.name, "/ret"}, O_FETCH);
  endtask

  initial begin
    bus.opcode = 4'b0000;
    bus.func   = 9'h000;

    vecs.push_back(mkv("lda",   4'b0000, 9'h000, 4, O_MEM_RD, O_LDA_WB));
    vecs.push_back(mkv("sta",   4'b0001, 9'h000, 3, O_MEM_WR, O_ZERO));
    vecs.push_back(mkv("jmp",   4'b0010, 9'h000, 3, O_JUMP,   O_ZERO));
    vecs.push_back(mkv("bz",    4'b0100, 9'h000, 3, O_BRANCH, O_ZERO));
    vecs.push_back(mkv("addi",  4'b1000, 9'h000, 4, O_IMM,    O_WB));
    vecs.push_back(mkv("subi",  4'b1001, 9'h000, 4, O_IMM,    O_WB));
    vecs.push_back(mkv("ori",   4'b1011, 9'h1ff, 4, O_IMM,    O_WB));
    vecs.push_back(mkv("mvto",  4'b0111, 9'h001, 4, cex(3'b101), O_WB_MT));
    vecs.push_back(mkv("mvfr",  4'b0111, 9'h002, 4, cex(3'b110), O_WB));
    vecs.push_back(mkv("cadd",  4'b0111, 9'h004, 4, cex(3'b000), O_WB));
    vecs.push_back(mkv("csub",  4'b0111, 9'h008, 4, cex(3'b001), O_WB));
    vecs.push_back(mkv("cand",  4'b0111, 9'h010, 4, cex(3'b010), O_WB));
    vecs.push_back(mkv("cor",   4'b0111, 9'h020, 4, cex(3'b011), O_WB));
    vecs.push_back(mkv("cnot",  4'b0111, 9'h040, 4, cex(3'b100), O_WB));
    vecs.push_back(mkv("cnop",  4'b0111, 9'h080, 2, O_ZERO, O_ZERO));
`ifndef ILLEGAL_TRAP_EN
    vecs.push_back(mkv("ill_op",  4'b1111, 9'h000, 2, O_ZERO, O_ZERO));
    vecs.push_back(mkv("ill_two", 4'b0111, 9'h003, 2, O_ZERO, O_ZERO));
    vecs.push_back(mkv("ill_b8",  4'b0111, 9'h100, 2, O_ZERO, O_ZERO));
`endif

    step();
    chk("rst_c1", O_ZERO);
    step();
    chk("rst_c2", O_ZERO);
    rst = 1'b0;
    #1;
    chk("first_fetch", O_FETCH);

    foreach (vecs[i]) run_vec(vecs[i]);

    // MOVETO: change IR fields once in C_EX; decoded op and RegDst must hold.
    bus.opcode = 4'b0111; bus.func = 9'h001;
    step();
    chk("latch/decode", O_ZERO);
    step();
    bus.opcode = 4'b0000; bus.func = 9'h004;
    #1;
    chk("latch/c_ex", cex(3'b101));
    step();
    chk("latch/alu_wb", O_WB_MT);
    step();
    chk("latch/ret", O_FETCH);

    // Reset landing in MEM_WR must suppress MemWrite and restart in FETCH.
    bus.opcode = 4'b0001; bus.func = 9'h000;
    step();
    chk("rstmw/decode", O_ZERO);
    step();
    chk("rstmw/mem_wr", O_MEM_WR);
    rst = 1'b1;
    #1;
    chk("rstmw/forced0", O_ZERO);
    step();
    chk("rstmw/held", O_ZERO);
    rst = 1'b0;
    #1;
    chk("rstmw/fetch", O_FETCH);

`ifdef ILLEGAL_TRAP_EN
    bus.opcode = 4'b1111; bus.func = 9'h000;
    step();
    chk("trap/decode", O_ZERO);
    for (int unsigned k = 0; k < 10; k++) begin
      step();
      chk($sformatf("trap/hold%0d", k), O_TRAP);
    end
    rst = 1'b1;
    step();
    chk("trap/rst", O_ZERO);
    rst = 1'b0;
    #1;
    chk("trap/fetch", O_FETCH);

    bus.opcode = 4'b0111; bus.func = 9'h003;
    step();
    chk("trapf/decode", O_ZERO);
    step();
    chk("trapf/trap", O_TRAP);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("trapf/fetch", O_FETCH);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
